e_mdu: RTL and testbench

E_MDU -- requirements
Module: e_mdu

---
 rtl/e_mdu_pkg.sv | 21 ++
 rtl/e_mdu.sv | 140 ++++++++++++++
 tb/tb_e_mdu.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/e_mdu_pkg.sv
// Definitions shared by the E-stage controller, the hazard unit and the MDU:
// the MDUop encodings and the multiply/divide latencies.
package e_mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;
  localparam int CNT_W       = 4;

endpackage

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit holding the architectural HI/LO registers.
// The result is computed when Start is accepted and parked until the latency
// counter expires, at which point HI/LO are committed and Busy drops.
// Optional feature: define MDU_DIV_EN to build in DIV/DIVU; without it those
// opcodes behave as NONE.
module e_mdu
  import e_mdu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUop,
  input  logic        Start,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  output logic        Busy,
  output logic [31:0] MDU_Out
);

  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      res_hi_q, res_hi_d;
  logic [31:0]      res_lo_q, res_lo_d;
  logic             commit_q, commit_d;   // false for divide-by-zero
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             is_mul, is_div, launch;
  logic signed [63:0] sa_ext, sb_ext;
  logic [63:0]      prod_s, prod_u;
  logic [31:0]      quo, rem;

  // Classify the incoming operation; DIV/DIVU only exist when compiled in.
  always_comb begin
    is_mul = (MDUop == MDU_MULT) || (MDUop == MDU_MULTU);
`ifdef MDU_DIV_EN
    is_div = (MDUop == MDU_DIV) || (MDUop == MDU_DIVU);
`else
    is_div = 1'b0;
`endif
    launch = Start && !busy_q && (is_mul || is_div);
  end

  // Datapath: products and quotient/remainder of the current operands.
  always_comb begin
    sa_ext = {{32{srcA[31]}}, srcA};
    sb_ext = {{32{srcB[31]}}, srcB};
    prod_s = sa_ext * sb_ext;
    prod_u = {32'd0, srcA} * {32'd0, srcB};
    quo    = 32'd0;
    rem    = 32'd0;
`ifdef MDU_DIV_EN
    if (srcB == 32'd0) begin
      quo = 32'd0;
      rem = 32'd0;
    end else if (MDUop == MDU_DIVU) begin
      quo = srcA / srcB;
      rem = srcA % srcB;
    end else if (srcA == 32'h8000_0000 && srcB == 32'hFFFF_FFFF) begin
      // The only signed overflow case: quotient wraps, remainder is zero.
      quo = 32'h8000_0000;
      rem = 32'd0;
    end else begin
      quo = 32'($signed(srcA) / $signed(srcB));
      rem = 32'($signed(srcA) % $signed(srcB));
    end
`endif
  end

  // Next-state: launch, count down/commit, or single-cycle MTHI/MTLO.
  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    commit_d = commit_q;
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    if (launch) begin
      busy_d   = 1'b1;
      cnt_d    = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      commit_d = !(is_div && srcB == 32'd0);
      if (is_div) begin
        res_hi_d = rem;
        res_lo_d = quo;
      end else if (MDUop == MDU_MULT) begin
        res_hi_d = prod_s[63:32];
        res_lo_d = prod_s[31:0];
      end else begin
        res_hi_d = prod_u[63:32];
        res_lo_d = prod_u[31:0];
      end
    end else if (busy_q) begin
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        cnt_d  = '0;
        if (commit_q) begin
          hi_d = res_hi_q;
          lo_d = res_lo_q;
        end
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else if (MDUop == MDU_MTHI) begin
      hi_d = srcA;
    end else if (MDUop == MDU_MTLO) begin
      lo_d = srcA;
    end
  end

  // State registers; reset aborts any in-flight operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      commit_q <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      commit_q <= commit_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
    end
  end

  // Read port: MFHI/MFLO see the committed (pre-commit during Busy) values.
  always_comb begin
    MDU_Out = 32'd0;
    if (MDUop == MDU_MFHI) MDU_Out = hi_q;
    else if (MDUop == MDU_MFLO) MDU_Out = lo_q;
  end

  assign Busy = busy_q;

endmodule

// File: tb/tb_e_mdu.sv
// Directed testbench for e_mdu. Inputs change on the falling edge and
// outputs are sampled there too, half a period away from the active edge.
module tb_e_mdu;
  import e_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  MDUop;
  logic        Start;
  logic [31:0] srcA, srcB;
  logic        Busy;
  logic [31:0] MDU_Out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  e_mdu dut (
    .clk(clk), .reset(reset), .MDUop(MDUop), .Start(Start),
    .srcA(srcA), .srcB(srcB), .Busy(Busy), .MDU_Out(MDU_Out)
  );

  // Issue a one-cycle Start; returns at the falling edge after the launch edge.
  task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    MDUop = op; Start = 1'b1; srcA = a; srcB = b;
    @(negedge clk);
    MDUop = MDU_NONE; Start = 1'b0; srcA = '0; srcB = '0;
  endtask

  // Count falling-edge samples with Busy high (bounded).
  task automatic wait_done(output int n);
    n = 0;
    while (Busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    MDUop = MDU_MFHI; #1 hi = MDU_Out;
    MDUop = MDU_MFLO; #1 lo = MDU_Out;
    MDUop = MDU_NONE;
  endtask

  task automatic write_hilo(input logic [3:0] op, input logic [31:0] v);
    @(negedge clk);
    MDUop = op; srcA = v;
    @(negedge clk);
    MDUop = MDU_NONE; srcA = '0;
  endtask

  task automatic test_reset();
    logic [31:0] hi, lo;
    reset = 1'b1; MDUop = MDU_NONE; Start = 1'b0; srcA = '0; srcB = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    read_hilo(hi, lo);
    $display("reset: Busy=%b HI=%h LO=%h", Busy, hi, lo);
    n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", Busy); end
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi got %h want 0", hi); end
    n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo got %h want 0", lo); end
    // Undefined opcode with Start must be ignored and read as zero.
    launch(4'd15, 32'd3, 32'd4);
    n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL bad_op_busy got %b want 0", Busy); end
  endtask

  task automatic test_mult();
    logic [31:0] hi, lo;
    int n;
    write_hilo(MDU_MTLO, 32'h0000_0077);
    launch(MDU_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
    read_hilo(hi, lo);
    n_checks++; if (lo !== 32'h0000_0077) begin n_fail++; $display("FAIL mult_precommit_lo got %h want 00000077", lo); end
    wait_done(n);
    read_hilo(hi, lo);
    $display("MULT ffffffff*2: busy=%0d HI=%h LO=%h", n, hi, lo);
    n_checks++; if (n !== 5) begin n_fail++; $display("FAIL mult_busy got %0d want 5", n); end
    n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi got %h want ffffffff", hi); end
    n_checks++; if (lo !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mult_lo got %h want fffffffe", lo); end
    launch(MDU_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
    wait_done(n);
    read_hilo(hi, lo);
    $display("MULTU ffffffff*2: busy=%0d HI=%h LO=%h", n, hi, lo);
    n_checks++; if (n !== 5) begin n_fail++; $display("FAIL multu_busy got %0d want 5", n); end
    n_checks++; if (hi !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_hi got %h want 00000001", hi); end
    n_checks++; if (lo !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_lo got %h want fffffffe", lo); end
  endtask

  task automatic test_mt();
    logic [31:0] hi, lo;
    write_hilo(MDU_MTHI, 32'hCAFE_0001);
    write_hilo(MDU_MTLO, 32'hCAFE_0002);
    read_hilo(hi, lo);
    $display("MTHI/MTLO: HI=%h LO=%h", hi, lo);
    n_checks++; if (hi !== 32'hCAFE_0001) begin n_fail++; $display("FAIL mthi got %h want cafe0001", hi); end
    n_checks++; if (lo !== 32'hCAFE_0002) begin n_fail++; $display("FAIL mtlo got %h want cafe0002", lo); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] hi, lo;
    int n;
    launch(MDU_MULT, 32'h0000_0010, 32'h0000_0010);
    n = 1;
    // Second Start during Busy: must not relaunch or change the result.
    MDUop = MDU_MULTU; Start = 1'b1; srcA = 32'd7; srcB = 32'd7;
    @(negedge clk);
    if (Busy === 1'b1) n++;
    Start = 1'b0; MDUop = MDU_MTLO; srcA = 32'h0000_AAAA; srcB = '0;
    @(negedge clk);
    if (Busy === 1'b1) n++;
    MDUop = MDU_NONE; srcA = '0;
    read_hilo(hi, lo);
    n_checks++; if (lo !== 32'hCAFE_0002) begin n_fail++; $display("FAIL busy_mtlo_precommit got %h want cafe0002", lo); end
    while (Busy === 1'b1 && n < 40) begin
      @(negedge clk);
      if (Busy === 1'b1) n++;
    end
    read_hilo(hi, lo);
    $display("MULT 16*16 with ignored Start/MTLO: busy=%0d HI=%h LO=%h", n, hi, lo);
    n_checks++; if (n !== 5) begin n_fail++; $display("FAIL b2b_busy got %0d want 5", n); end
    n_checks++; if (lo !== 32'h0000_0100) begin n_fail++; $display("FAIL b2b_lo got %h want 00000100", lo); end
    n_checks++; if (hi !== 32'h0000_0000) begin n_fail++; $display("FAIL b2b_hi got %h want 00000000", hi); end
  endtask

`ifdef MDU_DIV_EN
  task automatic test_div();
    logic [31:0] hi, lo;
    int n;
    launch(MDU_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done(n);
    read_hilo(hi, lo);
    $display("DIV -7/2: busy=%0d HI=%h LO=%h", n, hi, lo);
    n_checks++; if (n !== 10) begin n_fail++; $display("FAIL div_busy got %0d want 10", n); end
    n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_lo got %h want fffffffd", lo); end
    n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_hi got %h want ffffffff", hi); end
    launch(MDU_DIVU, 32'd7, 32'd2);
    wait_done(n);
    read_hilo(hi, lo);
    $display("DIVU 7/2: busy=%0d HI=%h LO=%h", n, hi, lo);
    n_checks++; if (lo !== 32'd3) begin n_fail++; $display("FAIL divu_lo got %h want 3", lo); end
    n_checks++; if (hi !== 32'd1) begin n_fail++; $display("FAIL divu_hi got %h want 1", hi); end
    write_hilo(MDU_MTHI, 32'h1234_5678);
    launch(MDU_DIV, 32'd5, 32'd0);
    wait_done(n);
    read_hilo(hi, lo);
    $display("DIV 5/0: busy=%0d HI=%h LO=%h", n, hi, lo);
    n_checks++; if (n !== 10) begin n_fail++; $display("FAIL div0_busy got %0d want 10", n); end
    n_checks++; if (hi !== 32'h1234_5678) begin n_fail++; $display("FAIL div0_hi got %h want 12345678", hi); end
    n_checks++; if (lo !== 32'd3) begin n_fail++; $display("FAIL div0_lo got %h want 3", lo); end
    launch(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n);
    read_hilo(hi, lo);
    $display("DIV 80000000/-1: HI=%h LO=%h", hi, lo);
    n_checks++; if (lo !== 32'h8000_0000) begin n_fail++; $display("FAIL divovf_lo got %h want 80000000", lo); end
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL divovf_hi got %h want 0", hi); end
  endtask
`else
  task automatic test_div_disabled();
    logic [31:0] hi, lo;
    launch(MDU_DIV, 32'd7, 32'd2);
    n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL nodiv_busy got %b want 0", Busy); end
    launch(MDU_DIVU, 32'd9, 32'd2);
    read_hilo(hi, lo);
    $display("DIV/DIVU disabled: Busy=%b HI=%h LO=%h", Busy, hi, lo);
    n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL nodivu_busy got %b want 0", Busy); end
    n_checks++; if (lo !== 32'h0000_0100) begin n_fail++; $display("FAIL nodiv_lo got %h want 00000100", lo); end
  endtask
`endif

  task automatic test_reset_inflight();
    logic [31:0] hi, lo;
    int n;
    write_hilo(MDU_MTHI, 32'h5555_0000);
`ifdef MDU_DIV_EN
    launch(MDU_DIV, 32'd100, 32'd7);
`else
    launch(MDU_MULT, 32'd100, 32'd7);
`endif
    repeat (3) @(negedge clk);
    // Reset together with an MTHI: reset wins.
    reset = 1'b1; MDUop = MDU_MTHI; srcA = 32'hDEAD_BEEF;
    @(negedge clk);
    reset = 1'b0; MDUop = MDU_NONE; srcA = '0;
    read_hilo(hi, lo);
    $display("reset in flight: Busy=%b HI=%h LO=%h", Busy, hi, lo);
    n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", Busy); end
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL rst_hi got %h want 0", hi); end
    n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL rst_lo got %h want 0", lo); end
    // Nothing left over from the aborted op may commit later.
    repeat (12) @(negedge clk);
    read_hilo(hi, lo);
    n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL rst_nocommit got %h want 0", lo); end
    launch(MDU_MULTU, 32'd3, 32'd4);
    wait_done(n);
    read_hilo(hi, lo);
    $display("MULTU 3*4 after reset: busy=%0d HI=%h LO=%h", n, hi, lo);
    n_checks++; if (n !== 5) begin n_fail++; $display("FAIL post_rst_busy got %0d want 5", n); end
    n_checks++; if (lo !== 32'd12) begin n_fail++; $display("FAIL post_rst_lo got %h want c", lo); end
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL post_rst_hi got %h want 0", hi); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_mt();
    test_back_to_back();
`ifdef MDU_DIV_EN
    test_div();
`else
    test_div_disabled();
`endif
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
